button_reader: RTL and testbench
================================

Name: button_reader

Overview:
- Memory-mapped IO responder that lets the CPU read push buttons through the same IO read/write bus used by the switch and LED peripherals.
- Synchronises and debounces N_BTN raw buttons and exposes their debounced level.
- Keeps sticky press flags; reading the flag register clears them, and so does a write-1-to-clear.
- Driven by the CPU clock; chip select comes from MemOrIO's address decode.

Parameters:
- N_BTN, 5, number of buttons; 1..16.
- DEB_CYCLES, 20000, consecutive stable cycles needed to accept a new level; at least 2.
- CNT_W, 15, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clock  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- btnread  in  1  IO read strobe (IORead).
- btnwrite  in  1  IO write strobe (IOWrite).
- btncs  in  1  chip select from the address decoder.
- btnaddr  in  2  address[1:0]; 2'b00 = LEVEL, 2'b10 = FLAGS, others reserved.
- btnwdata  in  16  IO write data; used only for FLAGS write-1-to-clear.
- btn_i  in  N_BTN  raw, asynchronous, bouncing button inputs; active-high.
- btnrdata  out  16  registered read data.
- btn_pend  out  1  OR of all FLAGS bits; status only, not an interrupt protocol.

Behaviour:
- Reset (reset==0 at a clock edge):
  - sync stages, stable levels, counters, flags and btnrdata all go to 0; btn_pend goes to 0.
  - Reset mid-debounce discards the partial count.
- Synchroniser: 2-flop chain per bit. s2 is the synchronised value, valid 2 edges after btn_i changes.
- Debounce, per bit i, independent state machine (IDLE / COUNTING):
  - s2[i]==stable[i]: cnt[i]<=0 (IDLE). Any bounce back restarts the count.
  - s2[i]!=stable[i] and cnt[i]<DEB_CYCLES-1: cnt[i]<=cnt[i]+1.
  - s2[i]!=stable[i] and cnt[i]==DEB_CYCLES-1: stable[i]<=s2[i] and cnt[i]<=0.
  - A clean input change therefore reaches stable DEB_CYCLES+2 edges after it is first sampled.
- Press flag: on an edge where stable[i] goes 0->1, flags[i]<=1. A 1->0 transition sets nothing.
- Read (btncs && btnread at an edge):
  - btnrdata <= zero-extended LEVEL (stable) or FLAGS; reserved addresses return 16'h0000.
  - Data is valid the cycle after the strobe, the same timing as the switch reader.
  - If not reading, btnrdata holds its value.
- Clear-on-read: a FLAGS read clears every flag that was returned.
  - A press event on the same edge wins: that flag is set after the edge, and the read returns the old value.
- Write (btncs && btnwrite && btnaddr==2'b10): flags <= flags & ~btnwdata[N_BTN-1:0].
  - A same-edge press event wins over the clear.
  - Writes to LEVEL or reserved addresses are ignored.
- Read and write on the same edge cannot happen (the control unit makes them exclusive). If they do occur, the read takes priority and the write is ignored.
- btn_pend: combinational |flags.
- btncs==0: strobes have no effect; debounce and flag capture keep running.

Decomposition:
- Shared package: address offsets (ADDR_LEVEL=2'b00, ADDR_FLAGS=2'b10), IO data width 16, the default DEB_CYCLES.
- One natural sub-module, btn_debounce: a single-bit synchroniser plus counter with parameter DEB_CYCLES and outputs stable and rise.
  - Instantiate it N_BTN times with a generate loop.
  - The top level holds the flags, the bus decode and btnrdata.

Test Plan:
All scenarios use DEB_CYCLES=4, N_BTN=5.
1. Reset: hold reset=0 for 3 cycles with btn_i=5'h1F -> btnrdata=0, btn_pend=0, and LEVEL reads 0 immediately after release.
2. Clean press: btn_i[2] 0->1 and held -> stable[2]=1 exactly 6 edges later; LEVEL read returns 16'h0004; btn_pend=1 from that edge onward.
3. Bounce: btn_i[0] toggles 1,0,1 with 2-cycle periods, then held 1 -> no LEVEL change until 4 consecutive stable samples; exactly one press flag (FLAGS=16'h0001).
4. Clear-on-read: FLAGS=16'h0005, read addr 2'b10 -> btnrdata=16'h0005 next cycle; a second read returns 16'h0000; btn_pend=0.
5. Read/press collision: a read of FLAGS on the same edge that stable[1] rises -> returns the old flags without bit 1; a following read returns 16'h0002.
6. W1C and reserved: FLAGS=16'h0003, write 16'h0001 to 2'b10 -> FLAGS=16'h0002; write to 2'b00 -> no change; read 2'b01 -> 16'h0000.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared definitions for the push-button IO responder.
//   IO_DW          : width of the IO read/write data bus
//   ADDR_LEVEL     : register offset returning the debounced button levels
//   ADDR_FLAGS     : register offset returning the sticky press flags
//   DEB_CYCLES_DEF : default number of stable cycles before a level is accepted
//   deb_state_e    : per-button debounce state
package button_reader_pkg;

  localparam int         IO_DW          = 16;
  localparam logic [1:0] ADDR_LEVEL     = 2'b00;
  localparam logic [1:0] ADDR_FLAGS     = 2'b10;
  localparam int         DEB_CYCLES_DEF = 20000;

  typedef enum logic {
    DEB_IDLE     = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/button_reader_debounce.sv
// Single-bit synchroniser and debouncer for one push button.
// Ports:
//   clk_i    : clock, all state changes on its rising edge
//   rst_ni   : synchronous active-low reset
//   btn_i    : raw asynchronous button input
//   stable_o : debounced level
//   rise_o   : high for the cycle in which stable_o is about to go 0->1
module btn_debounce
  import button_reader_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;

  // State register: synchroniser chain, debounce counter and accepted level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= DEB_IDLE;
      cnt_q    <= CNT_ZERO;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
    end
  end

  // Next state: count consecutive samples that disagree with the accepted level.
  always_comb begin
    s1_d     = btn_i;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      DEB_IDLE: begin
        // cnt is always zero here, and CNT_LAST >= 1, so the first mismatch just counts
        if (s2_q != stable_q) begin
          state_d = DEB_COUNTING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      DEB_COUNTING: begin
        if (s2_q == stable_q) begin
          // bounce back: discard the partial count
          state_d = DEB_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DEB_IDLE;
          cnt_d    = CNT_ZERO;
          stable_d = s2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DEB_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs: the accepted level and its about-to-rise strobe.
  always_comb begin
    stable_o = stable_q;
    rise_o   = stable_d & ~stable_q;
  end

endmodule

// File: rtl/button_reader.sv
// Memory-mapped push-button reader on the CPU IO bus.
// Ports:
//   clock     : CPU clock
//   reset     : synchronous active-low reset
//   btnread   : IO read strobe
//   btnwrite  : IO write strobe
//   btncs     : chip select from the address decoder
//   btnaddr   : register offset (00 = LEVEL, 10 = FLAGS, others reserved)
//   btnwdata  : write data, write-1-to-clear mask for FLAGS
//   btn_i     : raw, bouncing, active-high buttons
//   btnrdata  : registered read data, valid the cycle after the read strobe
//   btn_pend  : OR of all press flags
module button_reader
  import button_reader_pkg::*;
#(
  parameter int N_BTN      = 5,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btnread,
  input  logic             btnwrite,
  input  logic             btncs,
  input  logic [1:0]       btnaddr,
  input  logic [IO_DW-1:0] btnwdata,
  input  logic [N_BTN-1:0] btn_i,
  output logic [IO_DW-1:0] btnrdata,
  output logic             btn_pend
);

  // flags are kept IO-wide; bits at and above N_BTN are forced to zero by this mask
  localparam logic [IO_DW-1:0] VALID_MASK = {IO_DW{1'b1}} >> (IO_DW - N_BTN);
  localparam logic [IO_DW-1:0] ZERO_W     = {IO_DW{1'b0}};

  logic [N_BTN-1:0] stable_s;
  logic [N_BTN-1:0] rise_s;
  logic [IO_DW-1:0] level_s;
  logic [IO_DW-1:0] rise_ext_s;
  logic             rd_s;
  logic             wr_s;
  logic [IO_DW-1:0] flags_q, flags_d;
  logic [IO_DW-1:0] rdata_q, rdata_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk_i    (clock),
      .rst_ni   (reset),
      .btn_i    (btn_i[g]),
      .stable_o (stable_s[g]),
      .rise_o   (rise_s[g])
    );
  end

  assign level_s    = IO_DW'(stable_s);
  assign rise_ext_s = IO_DW'(rise_s);

  // Bus decode, read data mux and flag update; a same-edge press always wins.
  always_comb begin
    rd_s    = btncs & btnread;
    wr_s    = btncs & btnwrite & ~rd_s & (btnaddr == ADDR_FLAGS);
    rdata_d = rdata_q;
    flags_d = flags_q;
    if (rd_s) begin
      case (btnaddr)
        ADDR_LEVEL: rdata_d = level_s;
        ADDR_FLAGS: begin
          rdata_d = flags_q;
          flags_d = ZERO_W;
        end
        default:    rdata_d = ZERO_W;
      endcase
    end else if (wr_s) begin
      flags_d = flags_q & ~btnwdata;
    end else begin
      flags_d = flags_q;
    end
    flags_d = (flags_d | rise_ext_s) & VALID_MASK;
  end

  // Flag and read-data registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flags_q <= ZERO_W;
      rdata_q <= ZERO_W;
    end else begin
      flags_q <= flags_d;
      rdata_q <= rdata_d;
    end
  end

  assign btnrdata = rdata_q;
  assign btn_pend = |flags_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader (N_BTN=5, DEB_CYCLES=4).
module tb_button_reader;

  localparam int N   = 5;
  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btnread = 1'b0;
  logic        btnwrite = 1'b0;
  logic        btncs = 1'b0;
  logic [1:0]  btnaddr = 2'b00;
  logic [15:0] btnwdata = 16'h0000;
  logic [N-1:0] btn_i = '0;
  logic [15:0] btnrdata;
  logic        btn_pend;

  int n_checks = 0;
  int n_fail   = 0;

  button_reader #(.N_BTN(N), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .btnread  (btnread),
    .btnwrite (btnwrite),
    .btncs    (btncs),
    .btnaddr  (btnaddr),
    .btnwdata (btnwdata),
    .btn_i    (btn_i),
    .btnrdata (btnrdata),
    .btn_pend (btn_pend)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // hist[j] = raw button vector sampled j+1 edges ago. The synchronised value seen
  // at an edge is the raw sample from two edges earlier, so the last DEB synchronised
  // samples are hist[1..DEB]. A level is accepted when all of them disagree with it.
  logic [N-1:0] hist [0:DEB];
  logic [N-1:0] stable_m = '0;
  logic [N-1:0] flags_m  = '0;
  logic [15:0]  rdata_m  = 16'h0000;
  bit           model_ok = 1'b0;

  always @(posedge clock) begin
    logic [N-1:0] old_stable;
    logic [N-1:0] old_flags;
    bit all_diff;
    if (!reset) begin
      stable_m = '0;
      flags_m  = '0;
      rdata_m  = 16'h0000;
      for (int j = 0; j <= DEB; j++) hist[j] = '0;
    end else begin
      old_stable = stable_m;
      old_flags  = flags_m;
      for (int i = 0; i < N; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (hist[j][i] == old_stable[i]) all_diff = 1'b0;
        if (all_diff) stable_m[i] = ~old_stable[i];
      end
      if (btncs && btnread) begin
        if (btnaddr == 2'b00)      rdata_m = 16'(old_stable);
        else if (btnaddr == 2'b10) begin rdata_m = 16'(old_flags); flags_m = '0; end
        else                       rdata_m = 16'h0000;
      end else if (btncs && btnwrite && btnaddr == 2'b10) begin
        flags_m = flags_m & ~btnwdata[N-1:0];
      end
      flags_m = flags_m | (stable_m & ~old_stable);
      for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = btn_i;
    end
    model_ok = 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_ok) begin
      check("rdata_cycle", btnrdata, rdata_m);
      check("pend_cycle", {15'h0000, btn_pend}, {15'h0000, |flags_m});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic bus_read(input logic [1:0] a);
    btncs = 1'b1; btnread = 1'b1; btnaddr = a;
    step(1);
    btncs = 1'b0; btnread = 1'b0; btnaddr = 2'b00;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    btncs = 1'b1; btnwrite = 1'b1; btnaddr = a; btnwdata = d;
    step(1);
    btncs = 1'b0; btnwrite = 1'b0; btnaddr = 2'b00; btnwdata = 16'h0000;
  endtask

  initial begin
    // 1. reset with all buttons pressed
    reset = 1'b0; btn_i = 5'h1F;
    step(3);
    check("rst_rdata", btnrdata, 16'h0000);
    check("rst_pend", {15'h0000, btn_pend}, 16'h0000);
    reset = 1'b1;
    bus_read(2'b00);
    check("rst_level", btnrdata, 16'h0000);
    btn_i = 5'h00;
    step(10);

    // 2. clean press on bit 2: accepted on the 6th edge
    btn_i[2] = 1'b1;
    step(5);
    check("press_pend_early", {15'h0000, btn_pend}, 16'h0000);
    step(1);
    check("press_pend", {15'h0000, btn_pend}, 16'h0001);
    bus_read(2'b00);
    check("press_level", btnrdata, 16'h0004);

    // 3. bounce on bit 0, then hold
    btn_i[0] = 1'b1; step(2);
    btn_i[0] = 1'b0; step(2);
    btn_i[0] = 1'b1; step(5);
    bus_read(2'b00);
    check("bounce_level_old", btnrdata, 16'h0004);
    bus_read(2'b00);
    check("bounce_level_new", btnrdata, 16'h0005);

    // 4. clear on read
    bus_read(2'b10);
    check("cor_first", btnrdata, 16'h0005);
    bus_read(2'b10);
    check("cor_second", btnrdata, 16'h0000);
    check("cor_pend", {15'h0000, btn_pend}, 16'h0000);

    // 5. FLAGS read on the edge bit 1 becomes stable
    btn_i[1] = 1'b1;
    step(5);
    bus_read(2'b10);
    check("coll_old", btnrdata, 16'h0000);
    check("coll_pend", {15'h0000, btn_pend}, 16'h0001);
    bus_read(2'b10);
    check("coll_new", btnrdata, 16'h0002);

    // 6. write-1-to-clear and reserved addresses
    btn_i = 5'b00100; step(8);
    btn_i = 5'b00111; step(8);
    bus_write(2'b10, 16'h0001);
    check("w1c_pend", {15'h0000, btn_pend}, 16'h0001);
    bus_write(2'b00, 16'hFFFF);
    bus_write(2'b11, 16'hFFFF);
    bus_read(2'b01);
    check("rsvd_read", btnrdata, 16'h0000);
    bus_read(2'b10);
    check("w1c_flags", btnrdata, 16'h0002);

    // 7. reset in the middle of a debounce
    btn_i = 5'b01111; step(3);
    reset = 1'b0; step(1);
    reset = 1'b1; step(3);
    bus_read(2'b00);
    check("midrst_level0", btnrdata, 16'h0000);
    step(2);
    bus_read(2'b00);
    check("midrst_level", btnrdata, 16'h000F);
    bus_read(2'b10);
    check("midrst_flags", btnrdata, 16'h000F);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
